// File: rtl/minz_sweep_driver.sv
// minz_sweep_driver: self-timed stimulus and capture stage for a 4-input logic block.
// On start it drives {a,b,c,d} = 0..15 in ascending order, holding each value
// for DWELL clocks. It samples z once per combination, SETTLE clocks into the
// dwell, and builds a 16-entry truth table and a count of its ones.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start             begin a sweep (accepted in IDLE only, and only without abort)
//   abort             cancel a sweep in progress (ignored outside DRIVE)
//   z                 output of the block under drive
//   a, b, c, d        current combination, a is the MSB
//   busy              high while the sweep is driving
//   done              one-cycle pulse when a full sweep completes
//   valid             truth_table/ones hold a complete sweep result
//   truth_table[15:0] bit i is z sampled while {a,b,c,d} == i
//                     (the name "table" is a reserved word)
//   ones[4:0]         number of ones in truth_table
module minz_sweep_driver #(
  parameter int unsigned DWELL  = 4,  // legal range 2..255
  parameter int unsigned SETTLE = 1   // must be below DWELL
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic        z,
  output logic        a,
  output logic        b,
  output logic        c,
  output logic        d,
  output logic        busy,
  output logic        done,
  output logic        valid,
  output logic [15:0] truth_table,
  output logic [4:0]  ones
);

  localparam int unsigned IDX_W  = 4;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned ONES_W = 5;
  localparam int unsigned TT_W   = 16;

  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DWELL - 1);
  localparam logic [CNT_W-1:0] CNT_SAMPLE = CNT_W'(SETTLE);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(15);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    abcd_q, abcd_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                valid_q, valid_d;
  logic [TT_W-1:0]     tt_q, tt_d;
  logic [ONES_W-1:0]   ones_q, ones_d;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      abcd_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      tt_q    <= '0;
      ones_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      abcd_q  <= abcd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      valid_q <= valid_d;
      tt_q    <= tt_d;
      ones_q  <= ones_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    abcd_d  = abcd_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    valid_d = valid_q;
    tt_d    = tt_q;
    ones_d  = ones_q;

    unique case (state_q)
      ST_IDLE: begin
        abcd_d = '0;
        // abort beats a simultaneous start
        if (start && !abort) begin
          state_d = ST_DRIVE;
          idx_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          valid_d = 1'b0;
          tt_d    = '0;
          ones_d  = '0;
        end
      end

      ST_DRIVE: begin
        if (abort) begin
          // Any sample due this cycle is dropped along with the sweep
          state_d = ST_IDLE;
          abcd_d  = '0;
          idx_d   = '0;
          cnt_d   = '0;
        end else begin
          busy_d = 1'b1;
          if (cnt_q == CNT_SAMPLE) begin
            tt_d[idx_q] = z;
            ones_d      = ones_q + ONES_W'(z);
          end
          if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            if (idx_q != IDX_LAST) begin
              idx_d  = idx_q + IDX_W'(1);
              abcd_d = idx_q + IDX_W'(1);
            end else begin
              state_d = ST_DONE;
              abcd_d  = '0;
              busy_d  = 1'b0;
              done_d  = 1'b1;
              valid_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      ST_DONE: begin
        // Single cycle; start and abort are both ignored here
        state_d = ST_IDLE;
        abcd_d  = '0;
      end

      default: begin
        state_d = ST_IDLE;
        abcd_d  = '0;
      end
    endcase
  end

  assign {a, b, c, d} = abcd_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign valid        = valid_q;
  assign truth_table  = tt_q;
  assign ones         = ones_q;

endmodule

// File: tb/tb_minz_sweep_driver.sv
// Testbench for minz_sweep_driver: randomized truth-table functions drive z,
// and a behavioural model (bit i of the table equals f(i); combination k/DWELL
// on cycle k) supplies every expected value.
module tb_minz_sweep_driver;

  localparam int DWELL  = 4;
  localparam int SETTLE = 1;
  localparam int SWEEP  = 16 * DWELL;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic        z;
  logic        a, b, c, d;
  logic        busy, done, valid;
  logic [15:0] truth_table;
  logic [4:0]  ones;

  logic [15:0] zfun_tt;   // function of {a,b,c,d} currently driven onto z

  int checks;
  int failures;

  minz_sweep_driver #(.DWELL(DWELL), .SETTLE(SETTLE)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .abort       (abort),
    .z           (z),
    .a           (a),
    .b           (b),
    .c           (c),
    .d           (d),
    .busy        (busy),
    .done        (done),
    .valid       (valid),
    .truth_table (truth_table),
    .ones        (ones)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign z = zfun_tt[{a, b, c, d}];

  // Watchdog: every task is cycle-bounded, this only guards against a stuck sim
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference function a&b | c&~d evaluated over all combinations
  function automatic logic [15:0] f_ab_or_cnd();
    logic [15:0] r;
    logic [3:0]  v;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      v    = 4'(i);
      r[i] = (v[3] & v[2]) | (v[1] & ~v[0]);
    end
    return r;
  endfunction

  function automatic logic [4:0] count_ones(input logic [15:0] t);
    int n;
    n = 0;
    for (int i = 0; i < 16; i++) n += int'(t[i]);
    return 5'(n);
  endfunction

  task automatic check_idle_outputs(input string name);
    checks++;
    if ({a, b, c, d} !== 4'b0 || busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL %s: abcd=%b busy=%b done=%b, required abcd=0000 busy=0 done=0",
               name, {a, b, c, d}, busy, done);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      checks++;
      if ({a, b, c, d, busy, done, valid} !== 7'b0 || truth_table !== 16'h0 || ones !== 5'd0) begin
        failures++;
        $display("FAIL reset_idle cyc%0d: abcd=%b busy=%b done=%b valid=%b table=%h ones=%0d, required all zero",
                 k, {a, b, c, d}, busy, done, valid, truth_table, ones);
      end
    end
  endtask

  // Full sweep of function tt; checks every cycle, the done cycle and the one after.
  task automatic test_sweep(input logic [15:0] tt, input string name, output logic [15:0] got_tt);
    logic [15:0] exp_tt;
    logic [4:0]  exp_ones;
    zfun_tt  = tt;
    exp_tt   = tt;
    exp_ones = count_ones(tt);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < SWEEP; k++) begin
      checks++;
      if (busy !== 1'b1 || done !== 1'b0 || {a, b, c, d} !== 4'(k / DWELL)) begin
        failures++;
        $display("FAIL %s drive cyc%0d: busy=%b done=%b abcd=%0d, required busy=1 done=0 abcd=%0d",
                 name, k, busy, done, {a, b, c, d}, k / DWELL);
      end
      @(negedge clk);
    end
    checks++;
    if (done !== 1'b1 || valid !== 1'b1 || busy !== 1'b0 || {a, b, c, d} !== 4'b0) begin
      failures++;
      $display("FAIL %s done_cycle: done=%b valid=%b busy=%b abcd=%b, required 1 1 0 0000",
               name, done, valid, busy, {a, b, c, d});
    end
    checks++;
    if (truth_table !== exp_tt || ones !== exp_ones) begin
      failures++;
      $display("FAIL %s result: table=%h ones=%0d, required table=%h ones=%0d",
               name, truth_table, ones, exp_tt, exp_ones);
    end
    got_tt = truth_table;
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || valid !== 1'b1 || busy !== 1'b0 || truth_table !== exp_tt) begin
      failures++;
      $display("FAIL %s after_done: done=%b valid=%b busy=%b table=%h, required 0 1 0 %h",
               name, done, valid, busy, truth_table, exp_tt);
    end
  endtask

  task automatic test_z_is_a();
    logic [15:0] got;
    test_sweep(16'hFF00, "z_eq_a", got);
  endtask

  task automatic test_minz_function();
    logic [15:0] got;
    test_sweep(f_ab_or_cnd(), "minz_fn", got);
    checks++;
    if (got !== 16'hF444) begin
      failures++;
      $display("FAIL minz_fn_const: table=%h, required F444", got);
    end
  endtask

  task automatic test_random_functions();
    logic [15:0] got;
    for (int r = 0; r < 3; r++) test_sweep(16'($urandom), "rand_fn", got);
  endtask

  task automatic test_abort();
    int          off;
    int          seen_done;
    logic [15:0] got;
    // start and abort together in IDLE: abort wins
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    check_idle_outputs("start_with_abort");
    // abort mid-dwell at combination 9, including the sample cycle
    for (int rep = 0; rep < 2; rep++) begin
      zfun_tt = 16'($urandom);
      off = (rep == 0) ? SETTLE : $urandom_range(DWELL - 2, 1);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (9 * DWELL + off) @(negedge clk);
      checks++;
      if ({a, b, c, d} !== 4'd9 || busy !== 1'b1) begin
        failures++;
        $display("FAIL abort_pre: abcd=%0d busy=%b, required abcd=9 busy=1", {a, b, c, d}, busy);
      end
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      checks++;
      if ({a, b, c, d} !== 4'b0 || busy !== 1'b0 || done !== 1'b0 || valid !== 1'b0) begin
        failures++;
        $display("FAIL abort_post: abcd=%b busy=%b done=%b valid=%b, required all zero",
                 {a, b, c, d}, busy, done, valid);
      end
      seen_done = 0;
      repeat (2 * DWELL) begin
        @(negedge clk);
        if (done === 1'b1 || busy === 1'b1) seen_done++;
      end
      checks++;
      if (seen_done != 0) begin
        failures++;
        $display("FAIL abort_quiet: %0d active cycles after abort, required 0", seen_done);
      end
    end
    test_sweep(16'($urandom), "after_abort", got);
  endtask

  task automatic test_start_held();
    int done_cnt;
    zfun_tt  = 16'($urandom);
    done_cnt = 0;
    start    = 1'b1;
    for (int k = 0; k <= SWEEP; k++) begin
      @(negedge clk);
      if (done === 1'b1) done_cnt++;
    end
    // start still high through the DONE cycle
    @(negedge clk);
    start = 1'b0;
    check_idle_outputs("start_in_done");
    repeat (DWELL * 2) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) done_cnt += 10;
    end
    checks++;
    if (done_cnt != 1) begin
      failures++;
      $display("FAIL start_held: done_count_code=%0d, required 1", done_cnt);
    end
    checks++;
    if (valid !== 1'b1 || truth_table !== zfun_tt || ones !== count_ones(zfun_tt)) begin
      failures++;
      $display("FAIL start_held_result: valid=%b table=%h ones=%0d, required 1 %h %0d",
               valid, truth_table, ones, zfun_tt, count_ones(zfun_tt));
    end
  endtask

  task automatic test_async_reset();
    logic [15:0] got;
    zfun_tt = f_ab_or_cnd();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10 * DWELL + 1) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({a, b, c, d, busy, done, valid} !== 7'b0 || truth_table !== 16'h0 || ones !== 5'd0) begin
      failures++;
      $display("FAIL async_reset: abcd=%b busy=%b done=%b valid=%b table=%h ones=%0d, required all zero",
               {a, b, c, d}, busy, done, valid, truth_table, ones);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_sweep(f_ab_or_cnd(), "post_reset", got);
    checks++;
    if (got !== 16'hF444) begin
      failures++;
      $display("FAIL post_reset_const: table=%h, required F444", got);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    zfun_tt  = 16'h0;
    rst_n    = 1'b0;
    start    = 1'b0;
    abort    = 1'b0;
    test_reset();
    test_z_is_a();
    test_minz_function();
    test_random_functions();
    test_abort();
    test_start_held();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
